// File: rtl/inst_fetch_ctrl_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

   localparam int unsigned XLEN       = 64;
   localparam int unsigned ILEN       = 32;
   localparam int unsigned INST_BYTES = 4;

   // Low PC bits that must be zero for a word-aligned fetch address.
   localparam logic [1:0] ALIGN_MASK = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } fetch_state_e;

   // Byte address of the last complete instruction word in a memory of mem_bytes bytes.
   function automatic logic [XLEN-1:0] last_addr(input int unsigned mem_bytes);
      logic [XLEN-1:0] words;
      words = XLEN'(mem_bytes / INST_BYTES);
      return (words - XLEN'(1)) * XLEN'(INST_BYTES);
   endfunction

endpackage

// File: rtl/inst_fetch_ctrl_if.sv
// Fetch bus: instruction memory port, decode valid/ready handshake and branch redirect.
interface inst_fetch_ctrl_if;
   import fetch_pkg::*;

   logic [XLEN-1:0] Inst_Address;
   logic [ILEN-1:0] Instruction;
   logic            inst_valid;
   logic            inst_ready;
   logic [ILEN-1:0] inst_out;
   logic [XLEN-1:0] pc_out;
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_target;

   // Fetch controller side.
   modport master (
      output Inst_Address, inst_valid, inst_out, pc_out,
      input  Instruction, inst_ready, redirect_valid, redirect_target
   );

   // Memory / decode / branch-unit side.
   modport slave (
      input  Inst_Address, inst_valid, inst_out, pc_out,
      output Instruction, inst_ready, redirect_valid, redirect_target
   );

endinterface

// File: rtl/inst_fetch_ctrl_perf_ctr.sv
// Saturating fetch/stall counter pair used when INST_FETCH_PERF_EN is defined.
module fetch_perf_ctr (
   input  logic        clk,
   input  logic        reset,
   input  logic        clr_i,
   input  logic        fetch_inc_i,
   input  logic        stall_inc_i,
   output logic [31:0] fetch_count_o,
   output logic [31:0] stall_count_o
);

   logic [31:0] fetch_q, fetch_d;
   logic [31:0] stall_q, stall_d;

   // Clear has priority; each counter sticks at all-ones.
   always_comb begin
      fetch_d = fetch_q;
      stall_d = stall_q;
      if (clr_i) begin
         fetch_d = '0;
         stall_d = '0;
      end else begin
         if (fetch_inc_i && (fetch_q != '1)) fetch_d = fetch_q + 32'd1;
         if (stall_inc_i && (stall_q != '1)) stall_d = stall_q + 32'd1;
      end
   end

   // Counter state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fetch_q <= '0;
         stall_q <= '0;
      end else begin
         fetch_q <= fetch_d;
         stall_q <= stall_d;
      end
   end

   assign fetch_count_o = fetch_q;
   assign stall_count_o = stall_q;

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, captures Instruction into an output register
// and hands it to decode over valid/ready. Handles redirects, backpressure and halting.
// Optional perf counters are enabled by defining INST_FETCH_PERF_EN.
module inst_fetch_ctrl
   import fetch_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC  = 64'h0,
   parameter int unsigned     MEM_BYTES = 121
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   inst_fetch_ctrl_if.master  bus,
   output logic               halted,
   output logic               fault
`ifdef INST_FETCH_PERF_EN
   ,
   output logic [31:0]        fetch_count,
   output logic [31:0]        stall_count
`endif
);

   localparam logic [XLEN-1:0] LAST_ADDR = last_addr(MEM_BYTES);

   fetch_state_e    state_q, state_d;
   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   logic [XLEN-1:0] pc_out_q, pc_out_d;
   logic [ILEN-1:0] inst_q, inst_d;
   logic            valid_q, valid_d;
   logic            halted_q, halted_d;
   logic            fault_q, fault_d;

   logic xfer;
   logic can_advance;

   assign xfer        = valid_q && bus.inst_ready;
   assign can_advance = !valid_q || bus.inst_ready;

   // Next-state: redirect beats end-of-memory, which beats capture; otherwise stall.
   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      pc_out_d   = pc_out_q;
      inst_d     = inst_q;
      valid_d    = valid_q;
      fault_d    = fault_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d    = RUN;
               fetch_pc_d = RESET_PC;
            end
         end
         RUN: begin
            if (bus.redirect_valid) begin
               // Flush the held instruction; a same-cycle transfer still completed.
               valid_d = 1'b0;
               if ((bus.redirect_target[1:0] & ALIGN_MASK) != 2'b00) begin
                  state_d = HALT;
                  fault_d = 1'b1;
               end else begin
                  fetch_pc_d = bus.redirect_target;
               end
            end else if (can_advance && (fetch_pc_q > LAST_ADDR)) begin
               state_d = HALT;
               fault_d = 1'b0;
               if (xfer) valid_d = 1'b0;
            end else if (can_advance) begin
               inst_d     = bus.Instruction;
               pc_out_d   = fetch_pc_q;
               valid_d    = 1'b1;
               fetch_pc_d = fetch_pc_q + XLEN'(INST_BYTES);
            end
         end
         HALT: begin
            // Drain only; a held instruction may still be taken by decode.
            if (xfer) valid_d = 1'b0;
            if (start) begin
               state_d    = RUN;
               fetch_pc_d = RESET_PC;
               fault_d    = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
      halted_d = (state_d == HALT);
   end

   // Registered FSM and outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         fetch_pc_q <= RESET_PC;
         pc_out_q   <= '0;
         inst_q     <= '0;
         valid_q    <= 1'b0;
         halted_q   <= 1'b0;
         fault_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         pc_out_q   <= pc_out_d;
         inst_q     <= inst_d;
         valid_q    <= valid_d;
         halted_q   <= halted_d;
         fault_q    <= fault_d;
      end
   end

   assign bus.Inst_Address = fetch_pc_q;
   assign bus.inst_valid   = valid_q;
   assign bus.inst_out     = inst_q;
   assign bus.pc_out       = pc_out_q;
   assign halted           = halted_q;
   assign fault            = fault_q;

`ifdef INST_FETCH_PERF_EN
   logic capture;
   logic stall;
   logic start_acc;

   assign capture   = (state_q == RUN) && !bus.redirect_valid && can_advance &&
                      (fetch_pc_q <= LAST_ADDR);
   assign stall     = (state_q == RUN) && valid_q && !bus.inst_ready;
   // start is only honoured outside RUN, so it only clears the counters there.
   assign start_acc = start && (state_q != RUN);

   fetch_perf_ctr u_perf (
      .clk           (clk),
      .reset         (reset),
      .clr_i         (start_acc),
      .fetch_inc_i   (capture),
      .stall_inc_i   (stall),
      .fetch_count_o (fetch_count),
      .stall_count_o (stall_count)
   );
`endif

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Testbench for inst_fetch_ctrl: scoreboard of expected decode transfers plus inline checks.
module tb_inst_fetch_ctrl;
   import fetch_pkg::*;

   logic clk = 1'b0;
   logic reset;
   logic start;
   logic halted;
   logic fault;
`ifdef INST_FETCH_PERF_EN
   logic [31:0] fetch_count;
   logic [31:0] stall_count;
`endif

   inst_fetch_ctrl_if bus ();

   int tests = 0;
   int fails = 0;

   typedef struct packed {
      logic [31:0] inst;
      logic [63:0] pc;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;

   always #5 clk = ~clk;

   inst_fetch_ctrl dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .bus         (bus),
      .halted      (halted),
      .fault       (fault)
`ifdef INST_FETCH_PERF_EN
      ,
      .fetch_count (fetch_count),
      .stall_count (stall_count)
`endif
   );

   // Instruction memory image.
   function automatic logic [31:0] mem_word(input logic [63:0] a);
      case (a)
         64'h00:  return 32'h10000913;
         64'h04:  return 32'h00700993;
         64'h08:  return 32'h07340663;
         64'h1C:  return 32'h04648663;
         64'h70:  return 32'hF8000CE3;
         64'h74:  return 32'h00000000;
         default: return {16'hA5A5, a[15:0]};
      endcase
   endfunction

   assign bus.Instruction = mem_word(bus.Inst_Address);

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input logic [31:0] inst, input logic [63:0] pc);
      sb.push_back({inst, pc});
   endtask

   // Every decode transfer must match the next scoreboard entry.
   always @(negedge clk) begin
      if (reset === 1'b1 && bus.inst_valid === 1'b1 && bus.inst_ready === 1'b1) begin
         tests++;
         if (sb.size() == 0) begin
            fails++;
            $display("FAIL xfer_unexpected: got inst=%h pc=%h, required no transfer",
                     bus.inst_out, bus.pc_out);
         end else begin
            mon_e = sb.pop_front();
            if (bus.inst_out !== mon_e.inst || bus.pc_out !== mon_e.pc) begin
               fails++;
               $display("FAIL xfer_data: got inst=%h pc=%h, required inst=%h pc=%h",
                        bus.inst_out, bus.pc_out, mon_e.inst, mon_e.pc);
            end
         end
      end
   end

   task automatic test_reset();
      reset = 1'b1;
      start = 1'b0;
      bus.inst_ready = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_target = '0;
      #1 reset = 1'b0;
      #2;
      tests++;
      if (bus.inst_valid !== 1'b0 || bus.inst_out !== 32'h0 || bus.pc_out !== 64'h0) begin
         fails++;
         $display("FAIL reset_out: got v=%b inst=%h pc=%h, required 0/0/0",
                  bus.inst_valid, bus.inst_out, bus.pc_out);
      end
      tests++;
      if (halted !== 1'b0 || fault !== 1'b0 || bus.Inst_Address !== 64'h0) begin
         fails++;
         $display("FAIL reset_state: got halted=%b fault=%b addr=%h, required 0/0/0",
                  halted, fault, bus.Inst_Address);
      end
      tick();
      tick();
      reset = 1'b1;
      tick();
      tests++;
      if (bus.inst_valid !== 1'b0 || halted !== 1'b0) begin
         fails++;
         $display("FAIL idle_hold: got v=%b halted=%b, required 0/0", bus.inst_valid, halted);
      end
   endtask

   task automatic test_stream();
      bus.inst_ready = 1'b1;
      push_exp(32'h10000913, 64'h0);
      push_exp(32'h00700993, 64'h4);
      start = 1'b1;
      tick();
      start = 1'b0;
      tests++;
      if (bus.Inst_Address !== 64'h0 || bus.inst_valid !== 1'b0) begin
         fails++;
         $display("FAIL start_load: got addr=%h v=%b, required 0/0",
                  bus.Inst_Address, bus.inst_valid);
      end
      tick();
      tests++;
      if (bus.inst_valid !== 1'b1 || bus.inst_out !== 32'h10000913 || bus.pc_out !== 64'h0) begin
         fails++;
         $display("FAIL first_inst: got v=%b inst=%h pc=%h, required 1/10000913/0",
                  bus.inst_valid, bus.inst_out, bus.pc_out);
      end
      tick();
      tests++;
      if (bus.inst_out !== 32'h00700993 || bus.pc_out !== 64'h4) begin
         fails++;
         $display("FAIL second_inst: got inst=%h pc=%h, required 00700993/4",
                  bus.inst_out, bus.pc_out);
      end
      bus.inst_ready = 1'b0;
   endtask

   task automatic test_backpressure();
      for (int i = 0; i < 3; i++) begin
         tests++;
         if (bus.inst_valid !== 1'b1 || bus.inst_out !== 32'h00700993 ||
             bus.pc_out !== 64'h4 || bus.Inst_Address !== 64'h8) begin
            fails++;
            $display("FAIL stall_hold[%0d]: got v=%b inst=%h pc=%h addr=%h, required 1/00700993/4/8",
                     i, bus.inst_valid, bus.inst_out, bus.pc_out, bus.Inst_Address);
         end
         tick();
      end
      push_exp(32'h07340663, 64'h8);
      bus.inst_ready = 1'b1;
      tick();
      tests++;
      if (bus.inst_out !== 32'h07340663 || bus.pc_out !== 64'h8) begin
         fails++;
         $display("FAIL stall_release: got inst=%h pc=%h, required 07340663/8",
                  bus.inst_out, bus.pc_out);
      end
   endtask

   task automatic test_redirect();
      bus.redirect_valid = 1'b1;
      bus.redirect_target = 64'h1C;
      tick();
      bus.redirect_valid = 1'b0;
      tests++;
      if (bus.inst_valid !== 1'b0 || bus.Inst_Address !== 64'h1C) begin
         fails++;
         $display("FAIL redirect_flush: got v=%b addr=%h, required 0/1c",
                  bus.inst_valid, bus.Inst_Address);
      end
      push_exp(32'h04648663, 64'h1C);
      tick();
      tests++;
      if (bus.inst_valid !== 1'b1 || bus.inst_out !== 32'h04648663 || bus.pc_out !== 64'h1C) begin
         fails++;
         $display("FAIL redirect_target: got v=%b inst=%h pc=%h, required 1/04648663/1c",
                  bus.inst_valid, bus.inst_out, bus.pc_out);
      end
   endtask

   task automatic test_misaligned();
      bus.redirect_valid = 1'b1;
      bus.redirect_target = 64'h22;
      tick();
      bus.redirect_valid = 1'b0;
      tests++;
      if (halted !== 1'b1 || fault !== 1'b1 || bus.inst_valid !== 1'b0 ||
          bus.Inst_Address !== 64'h20) begin
         fails++;
         $display("FAIL misalign_halt: got halted=%b fault=%b v=%b addr=%h, required 1/1/0/20",
                  halted, fault, bus.inst_valid, bus.Inst_Address);
      end
      bus.redirect_valid = 1'b1;
      bus.redirect_target = 64'h40;
      tick();
      bus.redirect_valid = 1'b0;
      tests++;
      if (halted !== 1'b1 || fault !== 1'b1 || bus.Inst_Address !== 64'h20) begin
         fails++;
         $display("FAIL halt_ignore_redirect: got halted=%b fault=%b addr=%h, required 1/1/20",
                  halted, fault, bus.Inst_Address);
      end
      push_exp(32'h10000913, 64'h0);
      start = 1'b1;
      tick();
      start = 1'b0;
      tests++;
      if (halted !== 1'b0 || fault !== 1'b0 || bus.Inst_Address !== 64'h0) begin
         fails++;
         $display("FAIL restart_clear: got halted=%b fault=%b addr=%h, required 0/0/0",
                  halted, fault, bus.Inst_Address);
      end
      tick();
      tests++;
      if (bus.inst_valid !== 1'b1 || bus.inst_out !== 32'h10000913 || bus.pc_out !== 64'h0) begin
         fails++;
         $display("FAIL restart_fetch: got v=%b inst=%h pc=%h, required 1/10000913/0",
                  bus.inst_valid, bus.inst_out, bus.pc_out);
      end
   endtask

   task automatic test_end_of_mem();
      bus.redirect_valid = 1'b1;
      bus.redirect_target = 64'h70;
      tick();
      bus.redirect_valid = 1'b0;
      push_exp(32'hF8000CE3, 64'h70);
      push_exp(32'h00000000, 64'h74);
      tick();
      tests++;
      if (bus.inst_out !== 32'hF8000CE3 || bus.pc_out !== 64'h70) begin
         fails++;
         $display("FAIL eom_0x70: got inst=%h pc=%h, required f8000ce3/70",
                  bus.inst_out, bus.pc_out);
      end
      tick();
      tests++;
      if (bus.inst_valid !== 1'b1 || bus.inst_out !== 32'h0 || bus.pc_out !== 64'h74 ||
          halted !== 1'b0) begin
         fails++;
         $display("FAIL eom_last: got v=%b inst=%h pc=%h halted=%b, required 1/0/74/0",
                  bus.inst_valid, bus.inst_out, bus.pc_out, halted);
      end
      tick();
      tests++;
      if (halted !== 1'b1 || fault !== 1'b0 || bus.inst_valid !== 1'b0 ||
          bus.Inst_Address !== 64'h78) begin
         fails++;
         $display("FAIL eom_halt: got halted=%b fault=%b v=%b addr=%h, required 1/0/0/78",
                  halted, fault, bus.inst_valid, bus.Inst_Address);
      end
      tick();
      tests++;
      if (halted !== 1'b1 || bus.Inst_Address !== 64'h78 || bus.inst_valid !== 1'b0) begin
         fails++;
         $display("FAIL eom_stay: got halted=%b addr=%h v=%b, required 1/78/0",
                  halted, bus.Inst_Address, bus.inst_valid);
      end
   endtask

   task automatic test_reset_mid_stall();
      bus.inst_ready = 1'b1;
      for (int i = 0; i < 4; i++) push_exp(mem_word(64'(i * 4)), 64'(i * 4));
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      bus.inst_ready = 1'b0;
      tests++;
      if (bus.inst_valid !== 1'b1 || bus.pc_out !== 64'h10 || bus.inst_out !== mem_word(64'h10)) begin
         fails++;
         $display("FAIL fifth_capture: got v=%b inst=%h pc=%h, required 1/%h/10",
                  bus.inst_valid, bus.inst_out, bus.pc_out, mem_word(64'h10));
      end
      for (int i = 0; i < 3; i++) tick();
`ifdef INST_FETCH_PERF_EN
      tests++;
      if (fetch_count !== 32'd5 || stall_count !== 32'd3) begin
         fails++;
         $display("FAIL perf_counts: got fetch=%0d stall=%0d, required 5/3",
                  fetch_count, stall_count);
      end
`endif
      tests++;
      if (sb.size() != 0) begin
         fails++;
         $display("FAIL sb_drained: got %0d pending, required 0", sb.size());
      end
      #2 reset = 1'b0;
      #1;
      tests++;
      if (bus.inst_valid !== 1'b0 || bus.pc_out !== 64'h0 || bus.Inst_Address !== 64'h0 ||
          halted !== 1'b0) begin
         fails++;
         $display("FAIL async_reset: got v=%b pc=%h addr=%h halted=%b, required 0/0/0/0",
                  bus.inst_valid, bus.pc_out, bus.Inst_Address, halted);
      end
`ifdef INST_FETCH_PERF_EN
      tests++;
      if (fetch_count !== 32'd0 || stall_count !== 32'd0) begin
         fails++;
         $display("FAIL perf_reset: got fetch=%0d stall=%0d, required 0/0",
                  fetch_count, stall_count);
      end
`endif
      tick();
      reset = 1'b1;
      bus.inst_ready = 1'b1;
      tick();
      tests++;
      if (bus.inst_valid !== 1'b0 || bus.Inst_Address !== 64'h0) begin
         fails++;
         $display("FAIL post_reset_idle: got v=%b addr=%h, required 0/0",
                  bus.inst_valid, bus.Inst_Address);
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect();
      test_misaligned();
      test_end_of_mem();
      test_reset_mid_stall();
      tests++;
      if (sb.size() != 0) begin
         fails++;
         $display("FAIL sb_final: got %0d pending, required 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "timeout");
   end

endmodule
